priority_encoder: RTL and testbench



---
 rtl/priority_encoder.sv | 71 +++++++
 tb/tb_priority_encoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/priority_encoder.sv
// Registered highest-set-bit encoder: WIDTH-bit request vector -> OUT_W-bit index + valid, one cycle latency.
// Optional PRIORITY_ENCODER_MULTI_EN adds a registered "more than one request" flag.
module priority_encoder #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid
`ifdef PRIORITY_ENCODER_MULTI_EN
  ,
  output logic             multi
`endif
);

  logic [OUT_W-1:0] out_d, out_q;
  logic             valid_d, valid_q;
  logic             seen;
`ifdef PRIORITY_ENCODER_MULTI_EN
  logic             multi_d, multi_q;
`endif

  // Ascending scan so the last hit (highest index) wins. in is only read
  // when enabled, keeping X on a disabled input away from the registers.
  always_comb begin
    out_d   = '0;
    valid_d = 1'b0;
    seen    = 1'b0;
`ifdef PRIORITY_ENCODER_MULTI_EN
    multi_d = 1'b0;
`endif
    if (!en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in[i]) begin
          out_d = OUT_W'(i);
`ifdef PRIORITY_ENCODER_MULTI_EN
          multi_d = multi_d | seen;
`endif
          seen  = 1'b1;
        end
      end
      valid_d = seen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

`ifdef PRIORITY_ENCODER_MULTI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) multi_q <= 1'b0;
    else        multi_q <= multi_d;
  end

  assign multi = multi_q;
`endif

  assign out   = out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Directed bench for priority_encoder (8-to-3): expected results queued at drive time,
// popped and compared one cycle later.
module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] in;
  logic [2:0] out;
  logic       valid;
`ifdef PRIORITY_ENCODER_MULTI_EN
  logic       multi;
`endif

  typedef struct {
    logic [2:0] out;
    logic       valid;
    logic       multi;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  priority_encoder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in),
    .out   (out),
    .valid (valid)
`ifdef PRIORITY_ENCODER_MULTI_EN
    ,
    .multi (multi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic e, input logic [7:0] v);
    exp_t r;
    logic found;
    r.out = 3'd0; r.valid = 1'b0; r.multi = 1'b0;
    found = 1'b0;
    if (!e && v != 8'h00) begin
      r.valid = 1'b1;
      r.multi = ($countones(v) > 1);
      for (int k = 7; k >= 0; k--) begin
        if (v[k] && !found) begin
          r.out = k[2:0];
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [7:0] v);
    en = e;
    in = v;
    q.push_back(model(e, v));
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".out"}, 32'(out), 32'(e.out));
      chk({tag, ".valid"}, 32'(valid), 32'(e.valid));
`ifdef PRIORITY_ENCODER_MULTI_EN
      chk({tag, ".multi"}, 32'(multi), 32'(e.multi));
`endif
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out"}, 32'(out), 32'd0);
    chk({tag, ".valid"}, 32'(valid), 32'd0);
`ifdef PRIORITY_ENCODER_MULTI_EN
    chk({tag, ".multi"}, 32'(multi), 32'd0);
`endif
  endtask

  initial begin
    logic [8:0] big;
    rst_n = 1'b0;
    en    = 1'b0;
    in    = 8'h80;

    // Reset held across three edges with a live request
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk_zero("reset");
    end
    rst_n = 1'b1;
    chk_zero("post_release");
    drive(1'b0, 8'h80);
    tick("first_after_reset");

    // One-hot sweep, back-to-back
    for (int b = 0; b < 8; b++) begin
      drive(1'b0, 8'(1 << b));
      tick("onehot");
    end

    // Priority
    drive(1'b0, 8'b0101_0011); tick("prio_53");
    drive(1'b0, 8'hFF);        tick("prio_ff");
    drive(1'b0, 8'b0000_0011); tick("prio_03");

    // Disable, including X on in
    drive(1'b1, 8'h10);        tick("dis_10");
    drive(1'b1, 8'hxx);        tick("dis_x");
    chk("dis_x.out_lit", 32'(out), 32'd0);
    drive(1'b0, 8'h10);        tick("en_10");
    chk("en_10.out_lit", 32'(out), 32'd4);

    // Zero and truncated 256
    drive(1'b0, 8'h00);        tick("zero");
    big = 9'h100;
    drive(1'b0, big[7:0]);     tick("trunc256");

    // Async reset between edges while out=5
    drive(1'b0, 8'h20);        tick("pre_rst");
    chk("pre_rst.out_lit", 32'(out), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("async_rst_hold");
    rst_n = 1'b1;
    drive(1'b0, 8'h44);        tick("after_rst");

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
